// File: rtl/if_id_queue_pkg.sv
// Shared widths for the fetch/decode queue, plus a push-size helper.
package if_id_queue_pkg;

  localparam int unsigned ADDR_BUS_WIDTH = 32;
  localparam int unsigned INST_BUS_WIDTH = 32;
  localparam int unsigned GHR_WIDTH      = 8;
  localparam int unsigned IFQ_DEPTH      = 8;

  // Number of entries a push carries; slot1 is only meaningful with slot0.
  function automatic logic [1:0] push_slots(input logic [1:0] valid);
    logic [1:0] n;
    n = '0;
    if (valid[0]) n = valid[1] ? 2'd2 : 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/if_id_queue_ring_ram_2w1r.sv
// DEPTH x WIDTH register array: two write ports, one asynchronous read port.
module ring_ram_2w1r #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we0_i,
  input  logic [$clog2(DEPTH)-1:0] waddr0_i,
  input  logic [WIDTH-1:0]         wdata0_i,
  input  logic                     we1_i,
  input  logic [$clog2(DEPTH)-1:0] waddr1_i,
  input  logic [WIDTH-1:0]         wdata1_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write addresses are always consecutive, so the two ports never collide.
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode queue: up to two pushes per cycle, one pop per cycle, single-cycle flush.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = IFQ_DEPTH,
  parameter int unsigned GHR_W  = GHR_WIDTH,
  parameter int unsigned ADDR_W = ADDR_BUS_WIDTH,
  parameter int unsigned INST_W = INST_BUS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_taken,
  input  logic [2*GHR_W-1:0]       in_pht_index,
  input  logic [2*ADDR_W-1:0]      in_pc,
  input  logic [2*INST_W-1:0]      in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_taken,
  output logic [GHR_W-1:0]         out_pht_index,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [INST_W-1:0]        out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 1 + GHR_W + ADDR_W + INST_W;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;
  logic [1:0]         push_n;
  logic [ENTRY_W-1:0] wdata0, wdata1, rdata;

  // Readiness depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count_q <= CNT_W'(DEPTH - 2));
  assign out_valid = (count_q != '0);
  assign push      = in_valid[0] && in_ready && !flush && !rst;
  assign pop       = out_valid && out_ready && !flush && !rst;
  assign push_n    = push ? push_slots(in_valid) : 2'd0;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wdata0 = {in_taken[0], in_pht_index[0 +: GHR_W], in_pc[0 +: ADDR_W], in_inst[0 +: INST_W]};
  assign wdata1 = {in_taken[1], in_pht_index[GHR_W +: GHR_W], in_pc[ADDR_W +: ADDR_W],
                   in_inst[INST_W +: INST_W]};

  ring_ram_2w1r #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk      (clk),
    .we0_i    (push),
    .waddr0_i (wr_ptr_q),
    .wdata0_i (wdata0),
    .we1_i    (push && in_valid[1]),
    .waddr1_i (wr_ptr_q + PTR_W'(1)),
    .wdata1_i (wdata1),
    .raddr_i  (rd_ptr_q),
    .rdata_o  (rdata)
  );

  always_comb begin
    out_taken     = '0;
    out_pht_index = '0;
    out_pc        = '0;
    out_inst      = '0;
    if (out_valid) begin
      out_taken     = rdata[ENTRY_W-1];
      out_pht_index = rdata[INST_W+ADDR_W +: GHR_W];
      out_pc        = rdata[INST_W +: ADDR_W];
      out_inst      = rdata[0 +: INST_W];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed scenarios plus a long random valid/ready run.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned GW    = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned IW    = 32;

  typedef struct packed {
    logic          tk;
    logic [GW-1:0] pht;
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [1:0]    in_valid, in_taken;
  logic          in_ready;
  logic [2*GW-1:0] in_pht_index;
  logic [2*AW-1:0] in_pc;
  logic [2*IW-1:0] in_inst;
  logic          out_valid, out_ready, out_taken;
  logic [GW-1:0] out_pht_index;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_inst;
  logic [3:0]    count;

  always #5 clk = ~clk;

  if_id_queue #(
    .DEPTH  (DEPTH),
    .GHR_W  (GW),
    .ADDR_W (AW),
    .INST_W (IW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_taken      (in_taken),
    .in_pht_index  (in_pht_index),
    .in_pc         (in_pc),
    .in_inst       (in_inst),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_taken     (out_taken),
    .out_pht_index (out_pht_index),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .count         (count)
  );

  ent_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic tk, input logic [7:0] ph);
    ent_t e;
    e.tk   = tk;
    e.pht  = ph;
    e.pc   = pc;
    e.inst = pc ^ 32'hC0DE_0000;
    return e;
  endfunction

  function automatic ent_t mkd(input logic [31:0] pc);
    return mk(pc, pc[2], pc[9:2]);
  endfunction

  task automatic drive(input logic [1:0] v, input ent_t e0, input ent_t e1);
    in_valid     = v;
    in_taken     = {e1.tk, e0.tk};
    in_pht_index = {e1.pht, e0.pht};
    in_pc        = {e1.pc, e0.pc};
    in_inst      = {e1.inst, e0.inst};
  endtask

  task automatic idle();
    in_valid = 2'b00;
  endtask

  // Capture what the DUT accepts at the negedge, commit to the model at the edge.
  task automatic tick();
    bit         pf;
    logic [1:0] v;
    ent_t       e0, e1;
    @(negedge clk);
    pf = in_valid[0] && in_ready && !flush && !rst;
    v  = in_valid;
    e0 = {in_taken[0], in_pht_index[GW-1:0], in_pc[AW-1:0], in_inst[IW-1:0]};
    e1 = {in_taken[1], in_pht_index[2*GW-1:GW], in_pc[2*AW-1:AW], in_inst[2*IW-1:IW]};
    @(posedge clk);
    if (rst || flush) exp_q.delete();
    else if (pf) begin
      exp_q.push_back(e0);
      if (v[1]) exp_q.push_back(e1);
    end
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    idle();
    for (int i = 0; i < 2 * DEPTH + 2 && out_valid; i++) tick();
    check("drain_done", {3'b0, out_valid}, 4'd0);
  endtask

  always @(negedge clk) begin
    assert (in_valid != 2'b10) else $error("FAIL in_valid_legal: got 2'b10");
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("count", count, exp_q.size());
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, exp_q.size() <= DEPTH - 2);
      if (exp_q.size() != 0) begin
        check("head", {out_taken, out_pht_index, out_pc, out_inst}, exp_q[0]);
        if (out_ready && !flush && !rst) void'(exp_q.pop_front());
      end else begin
        check("idle_zero", {out_taken, out_pht_index, out_pc, out_inst}, '0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  v;
    logic [31:0] pcn;
    int          r;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(2'b00, mkd(32'h0), mkd(32'h0));
    tick(); tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state and 2-wide push of 0x100/0x104.
    check("rst_count", count, 4'd0);
    check("rst_in_ready", {3'b0, in_ready}, 4'd1);
    check("rst_out_valid", {3'b0, out_valid}, 4'd0);
    out_ready = 1'b1;
    drive(2'b11, mkd(32'h100), mkd(32'h104));
    tick(); idle();
    check("t1_first_pc", out_pc, 32'h100);
    check("t1_count", count, 4'd2);
    tick();
    check("t1_second_pc", out_pc, 32'h104);
    tick();
    check("t1_empty", {3'b0, out_valid}, 4'd0);

    // Fill until not ready, then drain across pointer wrap.
    out_ready = 1'b0;
    for (int k = 0; k < 8 && in_ready; k++) begin
      drive(2'b11, mkd(32'h100 + 32'(8 * k)), mkd(32'h104 + 32'(8 * k)));
      tick();
    end
    idle();
    check("t2_full_count", count, 4'd8);
    check("t2_not_ready", {3'b0, in_ready}, 4'd0);
    drive(2'b11, mkd(32'h300), mkd(32'h304));
    tick(); idle();
    check("t2_push_dropped", count, 4'd8);
    check("t2_head", out_pc, 32'h100);
    drain();

    // Count 3, simultaneous 2-wide push and pop.
    out_ready = 1'b0;
    drive(2'b01, mkd(32'h400), mkd(32'h0));            tick();
    drive(2'b11, mkd(32'h404), mkd(32'h408));          tick();
    check("t3_count3", count, 4'd3);
    out_ready = 1'b1;
    drive(2'b11, mkd(32'h40C), mkd(32'h410));          tick();
    idle();
    check("t3_count4", count, 4'd4);
    check("t3_head", out_pc, 32'h404);
    drain();

    // Count 5, flush with push and pop active.
    out_ready = 1'b0;
    drive(2'b11, mkd(32'h500), mkd(32'h504));          tick();
    drive(2'b11, mkd(32'h508), mkd(32'h50C));          tick();
    drive(2'b01, mkd(32'h510), mkd(32'h0));            tick();
    check("t4_count5", count, 4'd5);
    flush = 1'b1; out_ready = 1'b1;
    drive(2'b11, mkd(32'h600), mkd(32'h604));          tick();
    flush = 1'b0; idle();
    check("t4_count0", count, 4'd0);
    check("t4_out_valid", {3'b0, out_valid}, 4'd0);
    check("t4_in_ready", {3'b0, in_ready}, 4'd1);
    drive(2'b01, mkd(32'h200), mkd(32'h0));            tick();
    idle();
    check("t4_first_after_flush", out_pc, 32'h200);
    drain();

    // Reset mid-stream at count 6, then taken/PHT round trip.
    out_ready = 1'b0;
    drive(2'b11, mkd(32'h700), mkd(32'h704));          tick();
    drive(2'b11, mkd(32'h708), mkd(32'h70C));          tick();
    drive(2'b11, mkd(32'h710), mkd(32'h714));          tick();
    check("t5_count6", count, 4'd6);
    rst = 1'b1; idle(); tick();
    rst = 1'b0;
    check("t5_outs_zero", {out_valid, out_taken, out_pht_index, out_pc, out_inst, count}, '0);
    check("t5_in_ready", {3'b0, in_ready}, 4'd1);
    drive(2'b01, mk(32'h800, 1'b1, 8'h2A), mkd(32'h0)); tick();
    idle();
    check("t5_taken", {3'b0, out_taken}, 4'd1);
    check("t5_pht", out_pht_index, 8'h2A);
    check("t5_pc", out_pc, 32'h800);
    drain();

    // Random valid/ready with occasional flush, checked by the scoreboard.
    pcn = 32'h1000;
    for (int c = 0; c < 10000; c++) begin
      r = $urandom_range(0, 2);
      v = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      drive(v, mk(pcn, pcn[4], pcn[11:4]), mk(pcn + 32'd4, pcn[5], pcn[12:5]));
      pcn = pcn + 32'd8;
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush = 1'b0;
    drain();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
